// File: rtl/psi_tuner_pkg.sv
// rtl/psi_tuner_pkg.sv - shared types and saturating step helper for the PSI period tuner
package psi_tuner_pkg;

  // Classification of one completed measurement against the target band
  typedef enum logic [1:0] {
    CMP_LOW  = 2'd0,
    CMP_EQ   = 2'd1,
    CMP_HIGH = 2'd2
  } cmp_t;

  // Saturating add/sub of an unsigned value by step, clamped to [0, max_val]
  function automatic logic [31:0] sat_step(
    input logic [31:0] val,
    input logic [31:0] step,
    input logic        up,
    input logic [31:0] max_val
  );
    logic [32:0] res;
    res = '0;
    if (up) begin
      res = {1'b0, val} + {1'b0, step};
      if (res > {1'b0, max_val}) begin
        res = {1'b0, max_val};
      end
    end else if (step <= val) begin
      res = {1'b0, val} - {1'b0, step};
    end
    return res[31:0];
  endfunction

endpackage

// File: rtl/psi_pulse_meter.sv
// rtl/psi_pulse_meter.sv - measures PSI high time in clk cycles with a saturating counter
module psi_pulse_meter
  import psi_tuner_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PSI,
  output logic [CNT_W-1:0] duration,
  output logic             measValid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prePSI_q,    prePSI_d;
  logic             armed_q,     armed_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] duration_q,  duration_d;
  logic             overflow_q,  overflow_d;
  logic             measValid_q, measValid_d;

  // Edge classification of {prePSI, PSI}; a pulse high before arming is never captured
  always_comb begin
    prePSI_d    = PSI;
    armed_d     = armed_q | ~PSI;
    count_d     = count_q;
    duration_d  = duration_q;
    overflow_d  = overflow_q;
    measValid_d = 1'b0;
    case ({prePSI_q, PSI})
      2'b01: begin
        if (armed_q) begin
          count_d = CNT_W'(1);
        end
      end
      2'b11: begin
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      2'b10: begin
        if (armed_q) begin
          duration_d  = count_q;
          overflow_d  = (count_q == CNT_MAX);
          measValid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Measurement state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prePSI_q    <= 1'b0;
      armed_q     <= 1'b0;
      count_q     <= '0;
      duration_q  <= '0;
      overflow_q  <= 1'b0;
      measValid_q <= 1'b0;
    end else begin
      prePSI_q    <= prePSI_d;
      armed_q     <= armed_d;
      count_q     <= count_d;
      duration_q  <= duration_d;
      overflow_q  <= overflow_d;
      measValid_q <= measValid_d;
    end
  end

  assign duration  = duration_q;
  assign measValid = measValid_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/psi_period_tuner.sv
// rtl/psi_period_tuner.sv - tunes a divider value so PSI high time tracks setPeriod
module psi_period_tuner
  import psi_tuner_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DIV_W      = 8,
  parameter int DIV_INIT   = (2 ** (DIV_W - 1)) - 1,
  parameter int STEP       = 1,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PSI,
  input  logic [CNT_W-1:0] setPeriod,
  input  logic             enable,
  input  logic             divLoad,
  input  logic [DIV_W-1:0] divLoadValue,
  output logic [CNT_W-1:0] duration,
  output logic             measValid,
  output logic             overflow,
  output logic [DIV_W-1:0] adjustedDiv,
  output logic             inBand,
  output logic             locked
);

  localparam int               LCW      = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [DIV_W-1:0] DIV_MAX  = '1;

  logic [DIV_W-1:0] adjustedDiv_q, adjustedDiv_d;
  logic             inBand_q,      inBand_d;
  logic             locked_q,      locked_d;
  logic [LCW-1:0]   lockCnt_q,     lockCnt_d;

  logic [CNT_W:0]   dur_x;
  logic [CNT_W:0]   set_x;
  logic [CNT_W:0]   tol_x;
  cmp_t             cmp;

  psi_pulse_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .PSI      (PSI),
    .duration (duration),
    .measValid(measValid),
    .overflow (overflow)
  );

  // One extra bit keeps setPeriod+TOL and duration+TOL from wrapping
  assign dur_x = {1'b0, duration};
  assign set_x = {1'b0, setPeriod};
  assign tol_x = (CNT_W + 1)'(TOL);

  // Band compare of the latest measurement; a saturated count naturally lands HIGH
  always_comb begin
    cmp = CMP_EQ;
    if (dur_x > set_x + tol_x) begin
      cmp = CMP_HIGH;
    end else if (dur_x + tol_x < set_x) begin
      cmp = CMP_LOW;
    end
  end

  // Adjust/load/lock: load wins over a coincident adjustment, disable clears lock state
  always_comb begin
    adjustedDiv_d = adjustedDiv_q;
    inBand_d      = inBand_q;
    locked_d      = locked_q;
    lockCnt_d     = lockCnt_q;
    if (!enable) begin
      inBand_d  = 1'b0;
      lockCnt_d = '0;
      locked_d  = 1'b0;
    end
    if (divLoad) begin
      adjustedDiv_d = divLoadValue;
      lockCnt_d     = '0;
      locked_d      = 1'b0;
    end else if (enable && measValid) begin
      case (cmp)
        CMP_HIGH: begin
          adjustedDiv_d = DIV_W'(sat_step(32'(adjustedDiv_q), 32'(STEP), 1'b1, 32'(DIV_MAX)));
          inBand_d      = 1'b0;
          lockCnt_d     = '0;
          locked_d      = 1'b0;
        end
        CMP_LOW: begin
          adjustedDiv_d = DIV_W'(sat_step(32'(adjustedDiv_q), 32'(STEP), 1'b0, 32'(DIV_MAX)));
          inBand_d      = 1'b0;
          lockCnt_d     = '0;
          locked_d      = 1'b0;
        end
        default: begin
          inBand_d = 1'b1;
          if (lockCnt_q != LOCK_MAX) begin
            lockCnt_d = lockCnt_q + LCW'(1);
          end
          locked_d = (lockCnt_d == LOCK_MAX);
        end
      endcase
    end
  end

  // Tuning state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adjustedDiv_q <= DIV_W'(DIV_INIT);
      inBand_q      <= 1'b0;
      locked_q      <= 1'b0;
      lockCnt_q     <= '0;
    end else begin
      adjustedDiv_q <= adjustedDiv_d;
      inBand_q      <= inBand_d;
      locked_q      <= locked_d;
      lockCnt_q     <= lockCnt_d;
    end
  end

  assign adjustedDiv = adjustedDiv_q;
  assign inBand      = inBand_q;
  assign locked      = locked_q;

endmodule
